// File: rtl/adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_pkg
//   Shared definitions for the byte-serial multi-precision adder:
//   - state_t   : sequencer state encoding (IDLE, RUN, DONE)
//   - BYTE_W    : width of the shared adder slice
//   - idx_width : width of the byte index register for a given operand size
//                 (ceil(log2(nbytes)), never less than one bit)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package adder_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-byte operand still needs a (constant-zero) index register.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage : adder_seq_pkg

// File: rtl/adder_slice8.sv
// -----------------------------------------------------------------------------
// adder_slice8
//   Purely combinational 8-bit carry-lookahead adder slice.
//
//   Ports:
//     a    in  8  addend byte
//     b    in  8  addend byte
//     cin  in  1  carry into bit 0
//     sum  out 8  a + b + cin, modulo 256
//     cout out 1  carry out of bit 7
//
//   Every carry is formed directly from the generate/propagate terms and cin
//   (c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin), so no carry depends
//   on a lower-order carry signal.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module adder_slice8
    import adder_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic term;
        logic prod;
        // NOTE: every variable written here gets a value before any
        // conditional or loop, so the block can never infer a latch.
        c    = '0;
        term = 1'b0;
        prod = 1'b0;
        c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            term = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = term | (prod & cin);
        end
    end

    assign sum  = p ^ c[BYTE_W-1:0];
    assign cout = c[BYTE_W];

endmodule : adder_slice8

// File: rtl/adder_byte_seq.sv
// -----------------------------------------------------------------------------
// adder_byte_seq
//   Multi-precision add sequencer. Adds two NBYTES-byte operands through one
//   shared 8-bit carry-lookahead slice, least-significant byte first, one byte
//   per cycle. The carry between bytes is held in a register.
//
//   Parameters:
//     NBYTES     operand width in bytes (1..16); W = 8*NBYTES
//
//   Ports:
//     clk        in  1  clock, rising edge
//     rst        in  1  synchronous active-high reset
//     in_valid   in  1  operand request valid
//     in_ready   out 1  high in IDLE (combinational from state)
//     in_a       in  W  operand A
//     in_b       in  W  operand B
//     in_cin     in  1  carry into byte 0
//     in_sub     in  1  subtract request (only with ADDER_BYTE_SEQ_SUB_EN)
//     out_valid  out 1  result valid (held until out_ready)
//     out_ready  in  1  consumer accepts result
//     out_sum    out W  sum (or difference) modulo 2^W
//     out_cout   out 1  carry out of top byte (1 = no borrow when subtracting)
//     busy       out 1  high in RUN or DONE
//
//   Build option:
//     ADDER_BYTE_SEQ_SUB_EN  adds in_sub; when set, B is inverted into the
//                            slice and byte-0 carry-in is forced to 1, giving
//                            A - B. Undefined: add-only, no in_sub port.
//
//   Timing: a request accepted at edge T shows out_valid after edge T+NBYTES.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module adder_byte_seq
    import adder_seq_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = BYTE_W * NBYTES
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
`ifdef ADDER_BYTE_SEQ_SUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         busy
);

    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry_q;
    logic [W-1:0]       sum_q;
    logic               cout_q;
    logic               out_valid_q;
    logic               sub_q;

    logic [BYTE_W-1:0]  slice_a;
    logic [BYTE_W-1:0]  slice_b;
    logic [BYTE_W-1:0]  slice_sum;
    logic               slice_cout;
    logic               start_carry;
    logic               start_sub;

    // ------------------------------------------------------------------
    // Request-time decode of the operation mode
    // ------------------------------------------------------------------
`ifdef ADDER_BYTE_SEQ_SUB_EN
    assign start_sub   = in_sub;
    // Two's-complement subtract: A + ~B + 1, so in_cin is ignored.
    assign start_carry = in_sub ? 1'b1 : in_cin;
`else
    assign start_sub   = 1'b0;
    assign start_carry = in_cin;
`endif

    // ------------------------------------------------------------------
    // Byte selection into the shared slice
    // ------------------------------------------------------------------
    assign slice_a = a_q[idx*BYTE_W +: BYTE_W];
    assign slice_b = sub_q ? ~b_q[idx*BYTE_W +: BYTE_W]
                           :  b_q[idx*BYTE_W +: BYTE_W];

    adder_slice8 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // ------------------------------------------------------------------
    // Sequencer, operand and result registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and result registers are reset as well, not
            // just the control state: out_sum is visible from reset and must
            // read zero, and an aborted partial result must not leak out.
            state       <= IDLE;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sub_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= start_carry;
                        sub_q   <= start_sub;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    sum_q[idx*BYTE_W +: BYTE_W] <= slice_sum;
                    carry_q                     <= slice_cout;
                    if (idx == LAST_IDX) begin
                        cout_q      <= slice_cout;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                DONE: begin
                    // Result registers are untouched here, so they hold
                    // steady for as long as the consumer stalls.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule : adder_byte_seq

// File: tb/tb_adder_byte_seq.sv
// -----------------------------------------------------------------------------
// tb_adder_byte_seq
//   Directed-vector bench for adder_byte_seq with NBYTES=4. Inputs are driven
//   and outputs sampled on the falling clock edge; the DUT acts on the rising
//   edge. Define ADDER_BYTE_SEQ_SUB_EN to include the subtract vectors.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adder_byte_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    localparam int BUDGET = 20;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int vectors    = 0;
    int miscompares = 0;

    adder_byte_seq #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADDER_BYTE_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for in_ready (bounded), present one request for one rising edge.
    // Returns at the falling edge right after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count falling edges until out_valid is seen (bounded).
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Accept the current result with a one-cycle out_ready pulse.
    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_cout, busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl: {in_ready,out_valid,out_cout,busy}=%b expected 1000",
                     {in_ready, out_valid, out_cout, busy});
        end
        vectors++;
        if (out_sum !== '0) begin
            miscompares++;
            $display("FAIL reset_sum: got %h expected 00000000", out_sum);
        end
    endtask

    task automatic test_full_ripple();
        bit ok;
        int cyc;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ripple_accept: in_ready never rose");
        end
        wait_valid(cyc);
        vectors++;
        if (cyc !== NBYTES) begin
            miscompares++;
            $display("FAIL ripple_latency: got %0d cycles expected %0d", cyc, NBYTES);
        end
        vectors++;
        if (out_sum !== 32'h0000_0000 || out_cout !== 1'b1) begin
            miscompares++;
            $display("FAIL ripple_result: got %h/%b expected 00000000/1", out_sum, out_cout);
        end
        consume();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ripple_release: out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_carry_in();
        bit ok;
        bit ready_seen;
        int n;
        ready_seen = 1'b0;
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, ok);
        n = 0;
        while (!out_valid && n < BUDGET) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) ready_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!ok || n !== NBYTES) begin
            miscompares++;
            $display("FAIL cin_latency: accepted=%b got %0d cycles expected %0d", ok, n, NBYTES);
        end
        vectors++;
        if (ready_seen || in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL cin_ready_low: in_ready=%b busy=%b seen_high=%b expected 0/1/0",
                     in_ready, busy, ready_seen);
        end
        vectors++;
        if (out_sum !== 32'hACF1_3569 || out_cout !== 1'b0) begin
            miscompares++;
            $display("FAIL cin_result: got %h/%b expected acf13569/0", out_sum, out_cout);
        end
        consume();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit unstable;
        int cyc;
        unstable = 1'b0;
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, ok);
        wait_valid(cyc);
        for (int k = 0; k < 10; k++) begin
            // Pulses of in_valid with fresh operands must be ignored.
            in_a     = 32'hDEAD_0000 + 32'(k);
            in_b     = 32'h0BAD_F00D;
            in_cin   = 1'b1;
            in_valid = k[0];
            @(negedge clk);
            if (out_valid !== 1'b1 || out_sum !== 32'h3333_3333 ||
                out_cout !== 1'b0 || in_ready !== 1'b0)
                unstable = 1'b1;
        end
        in_valid = 1'b0;
        vectors++;
        if (!ok || cyc !== NBYTES || unstable) begin
            miscompares++;
            $display("FAIL bp_hold: accepted=%b latency=%0d unstable=%b sum=%h expected 1/%0d/0/33333333",
                     ok, cyc, unstable, out_sum, NBYTES);
        end
        consume();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_idle: in_ready=%b out_valid=%b busy=%b expected 1/0/0",
                     in_ready, out_valid, busy);
        end
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, ok);
        wait_valid(cyc);
        vectors++;
        if (!ok || cyc !== NBYTES || out_sum !== 32'h0000_0003 || out_cout !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_next: accepted=%b latency=%0d got %h/%b expected 1/%0d/00000003/0",
                     ok, cyc, out_sum, out_cout, NBYTES);
        end
        consume();
    endtask

    task automatic test_mid_run_reset();
        bit ok;
        bit pulse;
        int cyc;
        pulse = 1'b0;
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, ok);
        // Now in the first RUN cycle; move to the second, then reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({in_ready, out_valid, out_cout, busy} !== 4'b1000 || out_sum !== '0) begin
            miscompares++;
            $display("FAIL mrr_state: {in_ready,out_valid,out_cout,busy}=%b sum=%h expected 1000/00000000",
                     {in_ready, out_valid, out_cout, busy}, out_sum);
        end
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) pulse = 1'b1;
        end
        vectors++;
        if (pulse) begin
            miscompares++;
            $display("FAIL mrr_no_pulse: out_valid rose after abort, expected none");
        end
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, ok);
        wait_valid(cyc);
        vectors++;
        if (!ok || cyc !== NBYTES || out_sum !== 32'h0000_0007 || out_cout !== 1'b0) begin
            miscompares++;
            $display("FAIL mrr_after: accepted=%b latency=%0d got %h/%b expected 1/%0d/00000007/0",
                     ok, cyc, out_sum, out_cout, NBYTES);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va   [3];
        logic [W-1:0] vb   [3];
        logic         vc   [3];
        logic [W-1:0] esum [3];
        logic         ecout[3];
        int  sent;
        int  got;
        int  last_acc;
        int  cyc;
        bit  pending;
        va[0] = 32'h0000_0001; vb[0] = 32'h0000_00FF; vc[0] = 1'b0;
        esum[0] = 32'h0000_0100; ecout[0] = 1'b0;
        va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; vc[1] = 1'b0;
        esum[1] = 32'h0000_0000; ecout[1] = 1'b1;
        va[2] = 32'h0000_FFFF; vb[2] = 32'h0000_FFFF; vc[2] = 1'b1;
        esum[2] = 32'h0001_FFFF; ecout[2] = 1'b0;
        sent = 0; got = 0; last_acc = -1; pending = 1'b0;
        @(negedge clk);
        in_a = va[0]; in_b = vb[0]; in_cin = vc[0]; in_sub = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 40 && got < 3; cyc++) begin
            if (pending) begin
                pending = 1'b0;
                if (sent < 3) begin
                    in_a = va[sent]; in_b = vb[sent]; in_cin = vc[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                vectors++;
                if (out_sum !== esum[got] || out_cout !== ecout[got]) begin
                    miscompares++;
                    $display("FAIL b2b_result%0d: got %h/%b expected %h/%b",
                             got, out_sum, out_cout, esum[got], ecout[got]);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                if (last_acc >= 0) begin
                    vectors++;
                    if (cyc - last_acc !== NBYTES + 2) begin
                        miscompares++;
                        $display("FAIL b2b_spacing%0d: got %0d cycles expected %0d",
                                 sent, cyc - last_acc, NBYTES + 2);
                    end
                end
                last_acc = cyc;
                sent++;
                pending = 1'b1;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (got !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results expected 3", got);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef ADDER_BYTE_SEQ_SUB_EN
    task automatic test_subtract();
        bit ok;
        int cyc;
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, ok);
        wait_valid(cyc);
        vectors++;
        if (!ok || cyc !== NBYTES || out_sum !== 32'hFFFF_FFFE || out_cout !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_borrow: accepted=%b latency=%0d got %h/%b expected 1/%0d/fffffffe/0",
                     ok, cyc, out_sum, out_cout, NBYTES);
        end
        consume();
        send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, ok);
        wait_valid(cyc);
        vectors++;
        if (!ok || cyc !== NBYTES || out_sum !== 32'h0000_0002 || out_cout !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_noborrow: accepted=%b latency=%0d got %h/%b expected 1/%0d/00000002/1",
                     ok, cyc, out_sum, out_cout, NBYTES);
        end
        consume();
    endtask
`endif

    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        test_reset();
        test_full_ripple();
        test_carry_in();
        test_backpressure();
        test_mid_run_reset();
        test_back_to_back();
`ifdef ADDER_BYTE_SEQ_SUB_EN
        test_subtract();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_adder_byte_seq
